switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Front end between the board DIP switches and the switch IO read block.
- Synchronizes the raw asynchronous switch levels into the clk domain.
- Filters mechanical bounce with a shared sample-tick prescaler and one stability counter per bit.
- Drives the clean 16-bit vector that the IO read block samples on CPU switch reads, plus a one-cycle change pulse.

Parameters:
- WIDTH, 16: number of switch bits.
- TICK_DIV, 100000: clk cycles per sample tick (1 ms at 100 MHz); legal range >= 1.
- STABLE_TICKS, 8: consecutive differing samples needed to commit a new level; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- sw_in  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_db  output  WIDTH  debounced switch levels; feeds the switch IO read block.
- sw_changed  output  1  one-cycle pulse when any sw_db bit changes.
- tick  output  1  sample strobe, for debug and test.

Behaviour:
- Reset (async, while rst=1): sync stages s1, s2 = 0; prescaler count = 0; all per-bit counters = 0; sw_db = 0; sw_changed = 0; tick = 0.
- Synchronizer:
  - s1 <= sw_in; s2 <= s1.
  - Only s2 is used downstream; sw_in is never sampled directly.
- Prescaler:
  - tcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is a registered output, asserted for exactly the one cycle in which tcnt == TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 every cycle after reset release.
- Per-bit filter, evaluated only on cycles where tick=1; non-tick cycles hold all counters and sw_db:
  - If s2[i] == sw_db[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_TICKS-1: sw_db[i] <= s2[i] and cnt[i] <= 0 (commit).
  - Else: cnt[i] <= cnt[i]+1.
  - cnt width is clog2(STABLE_TICKS), minimum 1 bit. It never wraps, because it saturates at the commit point.
- Glitch rejection: any tick where s2[i] matches sw_db[i] clears cnt[i]. A pulse shorter than STABLE_TICKS ticks never reaches sw_db.
- Bits are independent:
  - Several bits may commit on the same tick.
  - A bit may commit while other bits are mid-count.
- sw_changed:
  - Registered; equals 1 in the cycle sw_db first shows a new value, else 0.
  - Multiple bits committing together give a single one-cycle pulse.
- Latency with TICK_DIV=1: a level change applied before edge k appears on sw_db after edge k+1+STABLE_TICKS, i.e. 2 sync cycles plus STABLE_TICKS ticks.
- Reset mid-count: all progress is discarded. After release, switches already high re-qualify from scratch, taking 2 cycles plus STABLE_TICKS ticks.
- No combinational path from sw_in to any output.

Optional Feature:
- Macro: SW_EDGE_LATCH_EN
- When defined:
  - Adds input edge_clr [WIDTH] and output sw_rise [WIDTH], reset 0.
  - sw_rise[i] is set on the cycle sw_db[i] commits 0->1.
  - sw_rise[i] is cleared one cycle after edge_clr[i]=1.
  - Simultaneous set and clear on the same bit: set wins (bit stays 1).
  - Software polls sw_rise to catch switch flips between reads.
- When undefined: edge_clr, sw_rise and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 with sw_in=16'hFFFF -> sw_db=0, sw_changed=0, tick=0. Release with TICK_DIV=1, STABLE_TICKS=4 -> sw_db=16'hFFFF exactly 6 edges after release; sw_changed=1 for that single cycle.
- Clean change: TICK_DIV=1, STABLE_TICKS=4, sw_db=0; set sw_in=16'h00A5 before edge k -> sw_db=16'h00A5 after edge k+5, not earlier; one sw_changed pulse.
- Bounce: toggle sw_in[3] 1,0,1,0 every 2 cycles, then hold 1 (TICK_DIV=1, STABLE_TICKS=4) -> sw_db[3] stays 0 during bounce and becomes 1 exactly 6 edges after the final stable 1 is applied; no sw_changed pulse during bounce.
- Prescaler: TICK_DIV=3 -> tick high 1 cycle in 3. Hold sw_in=16'h8000 -> commit occurs only on the 4th qualifying tick edge; sw_db holds between ticks.
- Reset mid-count: start a 0->1 change on bit 0, assert rst after 2 ticks -> sw_db=0 and counters cleared. After release, full 2+4 edge latency is observed again.
- SW_EDGE_LATCH_EN build: commit bit 5 0->1 -> sw_rise=16'h0020. Pulse edge_clr=16'h0020 on the same cycle as a new bit-5 rise -> sw_rise[5] stays 1. Pulse edge_clr alone -> sw_rise[5]=0 next cycle.

Source files
------------

// File: rtl/switch_debouncer.sv
// Switch front end: 2-flop synchronizer, shared sample-tick prescaler and per-bit
// stability counters. Define SW_EDGE_LATCH_EN to add sticky rise flags (sw_rise/edge_clr).
module switch_debouncer #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
`ifdef SW_EDGE_LATCH_EN
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] sw_rise,
`endif
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_changed,
    output logic             tick
);

    localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   CW        = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [TW-1:0]    tcnt_q;
    logic [TW-1:0]    tcnt_d;
    logic             tick_q;
    logic             tick_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_db_q;
    logic [WIDTH-1:0] sw_db_d;
    logic             sw_changed_q;
    logic             sw_changed_d;

    always_comb begin
        tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + TW'(1);
        // tick is registered, so it is decoded from the next count value
        tick_d  = (tcnt_d == TICK_LAST);
        sw_db_d = sw_db_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (s2_q[i] == sw_db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    sw_db_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        sw_changed_d = (sw_db_d != sw_db_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            tcnt_q       <= '0;
            tick_q       <= 1'b0;
            sw_db_q      <= '0;
            sw_changed_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= sw_in;
            s2_q         <= s1_q;
            tcnt_q       <= tcnt_d;
            tick_q       <= tick_d;
            sw_db_q      <= sw_db_d;
            sw_changed_q <= sw_changed_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sw_db      = sw_db_q;
    assign sw_changed = sw_changed_q;
    assign tick       = tick_q;

`ifdef SW_EDGE_LATCH_EN
    logic [WIDTH-1:0] sw_rise_q;
    logic [WIDTH-1:0] sw_rise_d;

    // a new 0->1 commit overrides a clear requested in the same cycle
    always_comb begin
        sw_rise_d = (sw_rise_q & ~edge_clr) | (sw_db_d & ~sw_db_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rise_q <= '0;
        end else begin
            sw_rise_q <= sw_rise_d;
        end
    end

    assign sw_rise = sw_rise_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (TICK_DIV 1 and 3, STABLE_TICKS 4) checked
// every cycle against a sliding-window model, plus literal timing checks.
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  sw_in = '0;
    logic [W-1:0]  db0, db3;
    logic          chg0, chg3, tk0, tk3;
`ifdef SW_EDGE_LATCH_EN
    logic [W-1:0]  edge_clr = '0;
    logic [W-1:0]  rise0, rise3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(ST)) u_d1 (
        .clk(clk), .rst(rst), .sw_in(sw_in),
`ifdef SW_EDGE_LATCH_EN
        .edge_clr(edge_clr), .sw_rise(rise0),
`endif
        .sw_db(db0), .sw_changed(chg0), .tick(tk0)
    );

    switch_debouncer #(.WIDTH(W), .TICK_DIV(3), .STABLE_TICKS(ST)) u_d3 (
        .clk(clk), .rst(rst), .sw_in(sw_in),
`ifdef SW_EDGE_LATCH_EN
        .edge_clr('0), .sw_rise(rise3),
`endif
        .sw_db(db3), .sw_changed(chg3), .tick(tk3)
    );

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int td(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: an edge count since release, the raw samples seen at each edge, and for each
    // instance the last ST synchronized samples taken on tick cycles. A bit flips when all
    // ST of those window samples disagree with its current debounced level.
    int           n;
    logic [W-1:0] samp[$];
    logic [W-1:0] m_db [2];
    logic         m_chg [2];
    logic         m_tick [2];
    logic [W-1:0] win [2][ST];
    int           nwin [2];
    logic [W-1:0] syn, oldv, diff;
`ifdef SW_EDGE_LATCH_EN
    logic [W-1:0] m_rise;
    logic [W-1:0] old_db0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            samp.delete();
            for (int k = 0; k < 2; k++) begin
                m_db[k] = '0; m_chg[k] = 1'b0; m_tick[k] = 1'b0; nwin[k] = 0;
            end
`ifdef SW_EDGE_LATCH_EN
            m_rise = '0;
`endif
        end else begin
            n++;
            samp.push_back(sw_in);
            syn = (n >= 3) ? samp[n-3] : '0;
`ifdef SW_EDGE_LATCH_EN
            old_db0 = m_db[0];
`endif
            for (int k = 0; k < 2; k++) begin
                oldv = m_db[k];
                if (m_tick[k]) begin
                    for (int j = 0; j < ST-1; j++) win[k][j] = win[k][j+1];
                    win[k][ST-1] = syn;
                    if (nwin[k] < ST) nwin[k]++;
                    if (nwin[k] == ST) begin
                        diff = '1;
                        for (int j = 0; j < ST; j++) diff &= (win[k][j] ^ oldv);
                        m_db[k] = oldv ^ diff;
                    end
                end
                m_chg[k]  = (m_db[k] != oldv);
                m_tick[k] = ((n % td(k)) == td(k) - 1);
            end
`ifdef SW_EDGE_LATCH_EN
            m_rise = (m_rise & ~edge_clr) | (m_db[0] & ~old_db0);
`endif
        end
    end

    always @(negedge clk) begin
        cmp("db_td1", db0, m_db[0]);
        cmp("chg_td1", {15'b0, chg0}, {15'b0, m_chg[0]});
        cmp("tick_td1", {15'b0, tk0}, {15'b0, m_tick[0]});
        cmp("db_td3", db3, m_db[1]);
        cmp("chg_td3", {15'b0, chg3}, {15'b0, m_chg[1]});
        cmp("tick_td3", {15'b0, tk3}, {15'b0, m_tick[1]});
`ifdef SW_EDGE_LATCH_EN
        cmp("rise_td1", rise0, m_rise);
        cmp("rise_td3", rise3, 16'h0000);
`endif
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    int cnt;

    initial begin
        // reset with all switches high
        sw_in = 16'hFFFF;
        step(3);
        cmp("rst_db", db0, 16'h0000);
        cmp("rst_chg", {15'b0, chg0}, 16'h0);
        cmp("rst_tick", {15'b0, tk0}, 16'h0);
        cmp("rst_db_td3", db3, 16'h0000);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (e == 5) cmp("rel_db_early", db0, 16'h0000);
            if (e == 6) begin
                cmp("rel_db", db0, 16'hFFFF);
                cmp("rel_chg", {15'b0, chg0}, 16'h1);
            end
            if (e == 7)  cmp("rel_chg_end", {15'b0, chg0}, 16'h0);
            if (e == 11) cmp("rel_td3_early", db3, 16'h0000);
            if (e == 12) cmp("rel_td3", db3, 16'hFFFF);
        end

        // clean change
        sw_in = 16'h0000;
        step(20);
        sw_in = 16'h00A5;
        cnt = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            if (chg0) cnt++;
            if (e == 5) cmp("clean_early", db0, 16'h0000);
            if (e == 6) cmp("clean_db", db0, 16'h00A5);
        end
        cmp("clean_pulses", 16'(cnt), 16'd1);
        step(20);

        // bounce on bit 3
        cnt = 0;
        for (int p = 0; p < 4; p++) begin
            sw_in[3] = (p % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                step(1);
                if (chg0) cnt++;
            end
        end
        sw_in[3] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            if (e < 6 && chg0) cnt++;
            if (e == 5) cmp("bounce_early", {15'b0, db0[3]}, 16'h0);
            if (e == 6) cmp("bounce_db", {15'b0, db0[3]}, 16'h1);
        end
        cmp("bounce_pulses", 16'(cnt), 16'd0);
        step(20);

        // prescaler, phase aligned by reset
        rst = 1'b1;
        sw_in = 16'h8000;
        step(2);
        rst = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (tk3) cnt++;
            if (e == 2)  cmp("pre_tick_on", {15'b0, tk3}, 16'h1);
            if (e == 3)  cmp("pre_tick_off", {15'b0, tk3}, 16'h0);
            if (e == 6)  cmp("pre_td1_db", db0, 16'h8000);
            if (e == 11) cmp("pre_db_early", db3, 16'h0000);
            if (e == 12) cmp("pre_db", db3, 16'h8000);
        end
        cmp("pre_ticks", 16'(cnt), 16'd4);

        // reset mid-count
        sw_in = 16'h0000;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        sw_in = 16'h0001;
        step(4);
        rst = 1'b1;
        #1;
        cmp("mid_rst_db", db0, 16'h0000);
        step(2);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            if (e == 5) cmp("mid_early", db0, 16'h0000);
            if (e == 6) cmp("mid_db", db0, 16'h0001);
        end
        step(3);

`ifdef SW_EDGE_LATCH_EN
        edge_clr = '1;
        step(1);
        edge_clr = '0;
        cmp("rise_clr_all", rise0, 16'h0000);
        sw_in = 16'h0021;
        for (int e = 1; e <= 6; e++) step(1);
        cmp("rise_set", rise0, 16'h0020);
        sw_in = 16'h0001;
        step(10);
        cmp("rise_sticky", rise0, 16'h0020);
        sw_in = 16'h0021;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            if (e == 5) edge_clr = 16'h0020;
        end
        edge_clr = '0;
        cmp("rise_set_wins", rise0, 16'h0020);
        step(2);
        edge_clr = 16'h0020;
        step(1);
        edge_clr = '0;
        cmp("rise_clr", rise0, 16'h0000);
`endif

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
